// File: rtl/jstk2_poll_scheduler.sv
`default_nettype none
// ============================================================================
// jstk2_poll_scheduler -- frames 5-byte JSTK2 polls over an external SPI byte engine
// Revision 1.0
// ============================================================================
module jstk2_poll_scheduler #(
  parameter int unsigned SAMPLE_PERIOD_CYC = 100000,
  parameter int unsigned CS_SETUP_CYC      = 1000,
  parameter int unsigned BYTE_GAP_CYC      = 1500,
  parameter int unsigned TIMEOUT_CYC       = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [7:0] i_cmd,
  output logic       o_cs_n,
  output logic       o_byte_start,
  output logic [7:0] o_tx_byte,
  input  logic       i_byte_done,
  input  logic [7:0] i_rx_byte,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic [1:0] o_btn,
  output logic       o_valid,
  output logic       o_error,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CS_SETUP    = 3'd1,
    S_START       = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_GAP         = 3'd4,
    S_PERIOD_WAIT = 3'd5
  } state_t;

  localparam logic [31:0] C_SETUP_LAST   = 32'(CS_SETUP_CYC - 1);
  localparam logic [31:0] C_GAP_LAST     = 32'(BYTE_GAP_CYC - 1);
  localparam logic [31:0] C_TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] C_PERIOD_LAST  = 32'(SAMPLE_PERIOD_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  b0_q, b0_d;
  logic [1:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;
  logic [1:0]  b3_q, b3_d;
  logic        cs_n_q, cs_n_d;
  logic        byte_start_q, byte_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  btn_q, btn_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d = S_CS_SETUP;
          idx_d   = 3'd0;
          cmd_d   = i_cmd;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == C_SETUP_LAST) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done arriving on the terminal count still wins over the timeout.
        if (i_byte_done) begin
          case (idx_q)
            3'd0:    b0_d = i_rx_byte;
            3'd1:    b1_d = i_rx_byte[1:0];
            3'd2:    b2_d = i_rx_byte;
            3'd3:    b3_d = i_rx_byte[1:0];
            default: b0_d = b0_q;
          endcase
          if (idx_q == 3'd4) begin
            state_d = S_PERIOD_WAIT;
            x_d     = {b1_q, b0_q};
            y_d     = {b3_q, b2_q};
            btn_d   = i_rx_byte[1:0];
            valid_d = 1'b1;
          end else begin
            state_d = S_GAP;
            idx_d   = idx_q + 3'd1;
          end
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d = S_PERIOD_WAIT;
          error_d = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == C_GAP_LAST) state_d = S_START;
      end
      S_PERIOD_WAIT: begin
        if (cnt_q == C_PERIOD_LAST) begin
          if (i_enable) begin
            state_d = S_CS_SETUP;
            idx_d   = 3'd0;
            cmd_d   = i_cmd;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = 32'd0;

    // Outputs are registered versions of the state being entered.
    cs_n_d       = !((state_d == S_CS_SETUP) || (state_d == S_START) ||
                     (state_d == S_WAIT_DONE) || (state_d == S_GAP));
    byte_start_d = (state_d == S_START);
    tx_byte_d    = ((state_d == S_START) && (idx_d == 3'd0)) ? cmd_d : 8'h00;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      idx_q        <= 3'd0;
      cmd_q        <= 8'h00;
      b0_q         <= 8'h00;
      b1_q         <= 2'b00;
      b2_q         <= 8'h00;
      b3_q         <= 2'b00;
      cs_n_q       <= 1'b1;
      byte_start_q <= 1'b0;
      tx_byte_q    <= 8'h00;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      btn_q        <= 2'b00;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      cmd_q        <= cmd_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      b3_q         <= b3_d;
      cs_n_q       <= cs_n_d;
      byte_start_q <= byte_start_d;
      tx_byte_q    <= tx_byte_d;
      x_q          <= x_d;
      y_q          <= y_d;
      btn_q        <= btn_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign o_cs_n       = cs_n_q;
  assign o_byte_start = byte_start_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_btn        = btn_q;
  assign o_valid      = valid_q;
  assign o_error      = error_q;
  assign o_busy       = busy_q;

endmodule
`default_nettype wire
